// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin arbiter sharing one compare unit among NUM_REQ requesters.
// Contains cmp_types_pkg (cmp_op_t), the compare unit and the cmp_arbiter top.
// Ports (cmp_arbiter):
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     per-requester request handshake (one-hot ready)
//   req_a/req_b/req_op      per-requester operands and comparison op
//   req_tag                 per-requester opaque tag echoed on the response
//   rsp_valid/rsp_ready     per-requester response handshake
//   rsp_result/rsp_tag      shared response payload of the held stage
// Optional macro CMP_ARB_STATS_EN adds stat_grant_cnt (per-requester accepts)
// and stat_stall_cnt (cycles with a pending request but no accept), both saturating.

package cmp_types_pkg;
    typedef enum logic [2:0] {
        CMP_EQ  = 3'b000,
        CMP_NE  = 3'b001,
        CMP_LT  = 3'b100,
        CMP_GE  = 3'b101,
        CMP_LTU = 3'b110,
        CMP_GEU = 3'b111
    } cmp_op_t;
endpackage

module compare (
    input  logic [31:0]            a,
    input  logic [31:0]            b,
    input  cmp_types_pkg::cmp_op_t op,
    output logic                   result
);
    import cmp_types_pkg::*;
    // Encodings outside the enum fall through to 0.
    always_comb
        result = (op == CMP_EQ)  ? (a == b) :
                 (op == CMP_NE)  ? (a != b) :
                 (op == CMP_LT)  ? ($signed(a) <  $signed(b)) :
                 (op == CMP_GE)  ? ($signed(a) >= $signed(b)) :
                 (op == CMP_LTU) ? (a <  b) :
                 (op == CMP_GEU) ? (a >= b) : 1'b0;
endmodule

module cmp_arbiter
    import cmp_types_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic    [NUM_REQ-1:0]          req_valid,
    output logic    [NUM_REQ-1:0]          req_ready,
    input  logic    [NUM_REQ-1:0][31:0]    req_a,
    input  logic    [NUM_REQ-1:0][31:0]    req_b,
    input  cmp_op_t [NUM_REQ-1:0]          req_op,
    input  logic    [NUM_REQ-1:0][TAG_W-1:0] req_tag,
    output logic    [NUM_REQ-1:0]          rsp_valid,
    input  logic    [NUM_REQ-1:0]          rsp_ready,
    output logic                           rsp_result,
    output logic    [TAG_W-1:0]            rsp_tag
`ifdef CMP_ARB_STATS_EN
    ,
    output logic    [NUM_REQ-1:0][31:0]    stat_grant_cnt,
    output logic    [31:0]                 stat_stall_cnt
`endif
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]    rr_ptr, stage_id, gnt, gnt_hi, gnt_lo;
    logic             stage_valid, stage_result, hit_hi, cmp_res, can_accept, accept;
    logic [TAG_W-1:0] stage_tag;

    // First valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        gnt_hi = '0;
        gnt_lo = '0;
        hit_hi = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_lo = IW'(i);
                if (IW'(i) >= rr_ptr) begin
                    gnt_hi = IW'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        gnt = hit_hi ? gnt_hi : gnt_lo;
    end

    // A stalled stage blocks new accepts; a draining stage can be refilled in the same cycle.
    assign can_accept = !stage_valid || rsp_ready[stage_id];
    assign accept     = rst_n && can_accept && (|req_valid);
    assign req_ready  = accept ? (NUM_REQ'(1) << gnt) : '0;
    assign rsp_valid  = stage_valid ? (NUM_REQ'(1) << stage_id) : '0;
    assign rsp_result = stage_result;
    assign rsp_tag    = stage_tag;

    compare u_compare (
        .a      (req_a[gnt]),
        .b      (req_b[gnt]),
        .op     (req_op[gnt]),
        .result (cmp_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            stage_valid  <= 1'b0;
            stage_id     <= '0;
            stage_result <= 1'b0;
            stage_tag    <= '0;
        end else if (accept) begin
            stage_valid  <= 1'b1;
            stage_id     <= gnt;
            stage_result <= cmp_res;
            stage_tag    <= req_tag[gnt];
            rr_ptr       <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
        end else if (stage_valid && rsp_ready[stage_id]) begin
            stage_valid  <= 1'b0;
        end
    end

`ifdef CMP_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grant_cnt <= '0;
            stat_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i] && stat_grant_cnt[i] != '1)
                    stat_grant_cnt[i] <= stat_grant_cnt[i] + 32'd1;
            if ((|req_valid) && !accept && stat_stall_cnt != '1)
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed table-driven bench for cmp_arbiter (NUM_REQ=2, TAG_W=4).
module tb_cmp_arbiter;
    import cmp_types_pkg::*;

    localparam int N  = 2;
    localparam int TW = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic    [N-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
    logic    [N-1:0][31:0]  req_a, req_b;
    cmp_op_t [N-1:0]        req_op;
    logic    [N-1:0][TW-1:0] req_tag;
    logic                   rsp_result;
    logic    [TW-1:0]       rsp_tag;
`ifdef CMP_ARB_STATS_EN
    logic    [N-1:0][31:0]  stat_grant_cnt;
    logic    [31:0]         stat_stall_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cmp_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag)
`ifdef CMP_ARB_STATS_EN
        ,
        .stat_grant_cnt (stat_grant_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    typedef struct {
        logic [1:0]  vld, rrdy;
        logic [31:0] a0, b0, a1, b1;
        cmp_op_t     o0, o1;
        logic [3:0]  t0, t1;
        logic [1:0]  erdy, erv;
        logic        eres;
        logic [3:0]  etag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] vld, rrdy,
                       input logic [31:0] a0, b0, input cmp_op_t o0, input logic [3:0] t0,
                       input logic [31:0] a1, b1, input cmp_op_t o1, input logic [3:0] t1,
                       input logic [1:0] erdy, erv, input logic eres, input logic [3:0] etag);
        vec_t v;
        v.vld = vld; v.rrdy = rrdy;
        v.a0 = a0; v.b0 = b0; v.o0 = o0; v.t0 = t0;
        v.a1 = a1; v.b1 = b1; v.o1 = o1; v.t1 = t1;
        v.erdy = erdy; v.erv = erv; v.eres = eres; v.etag = etag;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [1:0] vld, rrdy,
                         input logic [31:0] a0, b0, input cmp_op_t o0, input logic [3:0] t0,
                         input logic [31:0] a1, b1, input cmp_op_t o1, input logic [3:0] t1);
        req_valid = vld; rsp_ready = rrdy;
        req_a[0] = a0; req_b[0] = b0; req_op[0] = o0; req_tag[0] = t0;
        req_a[1] = a1; req_b[1] = b1; req_op[1] = o1; req_tag[1] = t1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        drive(v.vld, v.rrdy, v.a0, v.b0, v.o0, v.t0, v.a1, v.b1, v.o1, v.t1);
        #1;
        n_vec++;
        chk($sformatf("v%0d_req_ready", idx), 32'(req_ready), 32'(v.erdy));
        chk($sformatf("v%0d_rsp_valid", idx), 32'(rsp_valid), 32'(v.erv));
        if (v.erv != 2'b00) begin
            chk($sformatf("v%0d_rsp_result", idx), 32'(rsp_result), 32'(v.eres));
            chk($sformatf("v%0d_rsp_tag", idx), 32'(rsp_tag), 32'(v.etag));
        end
    endtask

    initial begin
        cmp_op_t bad_op;
        bad_op = cmp_op_t'(3'b010);
        // Basic accept, signed LT
        add(2'b01, 2'b11, 32'hFFFFFFFF, 32'h1, CMP_LT, 4'd3, 0, 0, CMP_EQ, 0, 2'b01, 2'b00, 0, 0);
        add(2'b00, 2'b11, 0, 0, CMP_EQ, 0, 0, 0, CMP_EQ, 0, 2'b00, 2'b01, 1, 4'd3);
        // Req1 alone (unsigned LT), then alternating grants with both valid
        add(2'b10, 2'b11, 0, 0, CMP_EQ, 0, 32'h7FFFFFFF, 32'h80000000, CMP_LTU, 4'd2, 2'b10, 2'b00, 0, 0);
        add(2'b11, 2'b11, 5, 6, CMP_EQ, 4'd1, 32'h7FFFFFFF, 32'h80000000, CMP_LTU, 4'd2, 2'b01, 2'b10, 1, 4'd2);
        add(2'b11, 2'b11, 5, 6, CMP_EQ, 4'd1, 32'h7FFFFFFF, 32'h80000000, CMP_LTU, 4'd2, 2'b10, 2'b01, 0, 4'd1);
        add(2'b11, 2'b11, 5, 6, CMP_EQ, 4'd1, 32'h7FFFFFFF, 32'h80000000, CMP_LTU, 4'd2, 2'b01, 2'b10, 1, 4'd2);
        add(2'b11, 2'b11, 5, 6, CMP_EQ, 4'd1, 32'h7FFFFFFF, 32'h80000000, CMP_LTU, 4'd2, 2'b10, 2'b01, 0, 4'd1);
        add(2'b00, 2'b11, 0, 0, CMP_EQ, 0, 0, 0, CMP_EQ, 0, 2'b00, 2'b10, 1, 4'd2);
        // Backpressure: GEU held for 3 stalled cycles, req1 waits
        add(2'b01, 2'b00, 32'h80000000, 32'h7FFFFFFF, CMP_GEU, 4'd5, 0, 0, CMP_EQ, 0, 2'b01, 2'b00, 0, 0);
        add(2'b10, 2'b00, 0, 0, CMP_EQ, 0, 3, 3, CMP_NE, 4'd6, 2'b00, 2'b01, 1, 4'd5);
        add(2'b10, 2'b00, 0, 0, CMP_EQ, 0, 3, 3, CMP_NE, 4'd6, 2'b00, 2'b01, 1, 4'd5);
        add(2'b10, 2'b00, 0, 0, CMP_EQ, 0, 3, 3, CMP_NE, 4'd6, 2'b00, 2'b01, 1, 4'd5);
        add(2'b10, 2'b01, 0, 0, CMP_EQ, 0, 3, 3, CMP_NE, 4'd6, 2'b10, 2'b01, 1, 4'd5);
        // Drain-and-refill, signed GE, then undefined op on req0 (wraps past rr_ptr=1)
        add(2'b01, 2'b10, 0, 32'hFFFFFFFF, CMP_GE, 4'd7, 0, 0, CMP_EQ, 0, 2'b01, 2'b10, 0, 4'd6);
        add(2'b01, 2'b01, 1, 1, bad_op, 4'd8, 0, 0, CMP_EQ, 0, 2'b01, 2'b01, 1, 4'd7);
        add(2'b00, 2'b00, 0, 0, CMP_EQ, 0, 0, 0, CMP_EQ, 0, 2'b00, 2'b01, 0, 4'd8);

        // Reset state with both requesters valid
        drive(2'b11, 2'b00, 0, 0, CMP_EQ, 0, 0, 0, CMP_EQ, 0);
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            apply(i, vecs[i]);
            @(negedge clk);
        end

        // Reset while the stage is stalled: response dropped immediately, rr_ptr back to 0
        rst_n = 1'b0;
        drive(2'b11, 2'b00, 0, 0, CMP_EQ, 0, 0, 0, CMP_EQ, 0);
        #1;
        n_vec++;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst_req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b11, 2'b11, 1, 2, CMP_LTU, 4'd10, 1, 2, CMP_GE, 4'd11);
        #1;
        n_vec++;
        chk("postrst_req_ready", 32'(req_ready), 32'h1);
        chk("postrst_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        drive(2'b00, 2'b11, 0, 0, CMP_EQ, 0, 0, 0, CMP_EQ, 0);
        #1;
        n_vec++;
        chk("postrst_rsp_valid2", 32'(rsp_valid), 32'h1);
        chk("postrst_rsp_result", 32'(rsp_result), 32'h1);
        chk("postrst_rsp_tag", 32'(rsp_tag), 32'hA);

`ifdef CMP_ARB_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b01, 2'b01, 4, 4, CMP_EQ, 4'd1, 0, 0, CMP_EQ, 0);
        repeat (10) @(negedge clk);
        drive(2'b10, 2'b00, 0, 0, CMP_EQ, 0, 0, 0, CMP_EQ, 4'd2);
        repeat (2) @(negedge clk);
        drive(2'b00, 2'b00, 0, 0, CMP_EQ, 0, 0, 0, CMP_EQ, 0);
        #1;
        n_vec++;
        chk("stat_grant0", stat_grant_cnt[0], 32'd10);
        chk("stat_grant1", stat_grant_cnt[1], 32'd0);
        chk("stat_stall", stat_stall_cnt, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
